// File: rtl/hdmi_pkg.sv
// Shared encoder-mode encoding and period lengths for the HDMI period scheduler.
package hdmi_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL         = 3'd0,
    MODE_VIDEO        = 3'd1,
    MODE_VIDEO_GUARD  = 3'd2,
    MODE_ISLAND       = 3'd3,
    MODE_ISLAND_GUARD = 3'd4
  } mode_t;

  // Preamble nibbles are {CTL3,CTL2,CTL1,CTL0}.
  localparam logic [3:0] PREAMBLE_VIDEO  = 4'b0001;
  localparam logic [3:0] PREAMBLE_ISLAND = 4'b0101;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int ISLAND_LEN   = 32;

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters and registered sync levels; also exposes the next position
// so the scheduler can register its outputs in step with cx/cy.
module video_timing_counter #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk_pixel,
  input  logic        rst_pixel,
  output logic [10:0] cx,
  output logic [9:0]  cy,
  output logic [10:0] next_cx,
  output logic [9:0]  next_cy,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  always_comb begin
    next_cx = cx + 11'd1;
    next_cy = cy;
    if (cx == H_LAST) begin
      next_cx = '0;
      next_cy = (cy == V_LAST) ? '0 : cy + 10'd1;
    end
  end

  // Sync levels are computed from the next position so they land with cx/cy.
  always_ff @(posedge clk_pixel or posedge rst_pixel) begin
    if (rst_pixel) begin
      cx    <= '0;
      cy    <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
    end else begin
      cx    <= next_cx;
      cy    <= next_cy;
      hsync <= (next_cx >= HS_START && next_cx < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync <= (next_cy >= VS_START && next_cy < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel TMDS period scheduler: encoder mode, sync and CTL preambles for all channels.
// Data islands on ISLAND_LINE are built only when HDMI_DATA_ISLAND_EN is defined.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter bit          HSYNC_POL    = 1'b0,
  parameter bit          VSYNC_POL    = 1'b0,
  parameter int unsigned ISLAND_LINE  = 480,
  parameter int unsigned ISLAND_START = 16
) (
  input  logic        clk_pixel,
  input  logic        rst_pixel,
  output logic [2:0]  mode,
  output logic [1:0]  ctl0,
  output logic [1:0]  ctl1,
  output logic [1:0]  ctl2,
  output logic [10:0] cx,
  output logic [9:0]  cy,
  output logic        video_active,
  output logic [4:0]  island_idx,
  output logic        island_first
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned ISLAND_SPAN = PREAMBLE_LEN + GUARD_LEN + ISLAND_LEN + GUARD_LEN;

  if (H_BACK < 12 || ISLAND_LINE < V_ACTIVE || ISLAND_LINE >= V_TOTAL ||
      ISLAND_START + ISLAND_SPAN > H_TOTAL - PREAMBLE_LEN - GUARD_LEN) begin : g_bad_timing
    $error("hdmi_period_scheduler: unsupported timing parameters");
  end

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_V_PRE     = 3'd1;
  localparam logic [2:0] ST_V_GUARD   = 3'd2;
  localparam logic [2:0] ST_ACTIVE    = 3'd3;
  localparam logic [2:0] ST_ISL_PRE   = 3'd4;
  localparam logic [2:0] ST_ISL_GUARD = 3'd5;
  localparam logic [2:0] ST_ISL_DATA  = 3'd6;
  localparam logic [2:0] ST_ISL_TRAIL = 3'd7;

  localparam logic [10:0] V_PRE_COL     = 11'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [10:0] V_GUARD_COL   = 11'(H_TOTAL - GUARD_LEN);
  localparam logic [10:0] ACTIVE_COLS   = 11'(H_ACTIVE);
  localparam logic [9:0]  ACTIVE_LINES  = 10'(V_ACTIVE);
  localparam logic [9:0]  LAST_ACT_LINE = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  LAST_LINE     = 10'(V_TOTAL - 1);
  localparam logic [4:0]  PRE_LAST      = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]  GUARD_LAST    = 5'(GUARD_LEN - 1);
  localparam logic [4:0]  DATA_LAST     = 5'(ISLAND_LEN - 1);
`ifdef HDMI_DATA_ISLAND_EN
  localparam logic [9:0]  ISL_LINE      = 10'(ISLAND_LINE);
  localparam logic [10:0] ISL_COL       = 11'(ISLAND_START);
`endif

  logic [10:0] next_cx;
  logic [9:0]  next_cy;
  logic        hsync, vsync;
  logic [2:0]  state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        video_line, next_active;
  mode_t       mode_nx, mode_q;
  logic [3:0]  pre_nx;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE (V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk_pixel(clk_pixel),
    .rst_pixel(rst_pixel),
    .cx       (cx),
    .cy       (cy),
    .next_cx  (next_cx),
    .next_cy  (next_cy),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  assign ctl0 = {vsync, hsync};
  assign mode = mode_q;

  // A line carries the video preamble when the line after it is active.
  assign video_line  = (next_cy < LAST_ACT_LINE) || (next_cy == LAST_LINE);
  assign next_active = (next_cx < ACTIVE_COLS) && (next_cy < ACTIVE_LINES);

  // IDLE -> ACTIVE directly only happens at reset exit, where no preamble was possible.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 5'd1;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (video_line && next_cx == V_PRE_COL) state_nx = ST_V_PRE;
        else if (next_active)                   state_nx = ST_ACTIVE;
`ifdef HDMI_DATA_ISLAND_EN
        else if (next_cy == ISL_LINE && next_cx == ISL_COL) state_nx = ST_ISL_PRE;
`endif
      end
      ST_V_PRE:   if (next_cx == V_GUARD_COL) state_nx = ST_V_GUARD;
      ST_V_GUARD: if (next_cx == '0)          state_nx = ST_ACTIVE;
      ST_ACTIVE:  if (!next_active)           state_nx = ST_IDLE;
      ST_ISL_PRE: if (cnt == PRE_LAST) begin
        state_nx = ST_ISL_GUARD;
        cnt_nx   = '0;
      end
      ST_ISL_GUARD: if (cnt == GUARD_LAST) begin
        state_nx = ST_ISL_DATA;
        cnt_nx   = '0;
      end
      ST_ISL_DATA: if (cnt == DATA_LAST) begin
        state_nx = ST_ISL_TRAIL;
        cnt_nx   = '0;
      end
      ST_ISL_TRAIL: if (cnt == GUARD_LAST) begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    mode_nx = MODE_CTRL;
    pre_nx  = 4'b0000;
    case (state_nx)
      ST_V_PRE:                   pre_nx  = PREAMBLE_VIDEO;
      ST_V_GUARD:                 mode_nx = MODE_VIDEO_GUARD;
      ST_ACTIVE:                  mode_nx = MODE_VIDEO;
      ST_ISL_PRE:                 pre_nx  = PREAMBLE_ISLAND;
      ST_ISL_GUARD, ST_ISL_TRAIL: mode_nx = MODE_ISLAND_GUARD;
      ST_ISL_DATA:                mode_nx = MODE_ISLAND;
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge rst_pixel) begin
    if (rst_pixel) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      mode_q       <= MODE_CTRL;
      ctl1         <= 2'b00;
      ctl2         <= 2'b00;
      video_active <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      mode_q       <= mode_nx;
      ctl1         <= pre_nx[1:0];
      ctl2         <= pre_nx[3:2];
      video_active <= (state_nx == ST_ACTIVE);
    end
  end

`ifdef HDMI_DATA_ISLAND_EN
  always_ff @(posedge clk_pixel or posedge rst_pixel) begin
    if (rst_pixel) begin
      island_idx   <= '0;
      island_first <= 1'b0;
    end else begin
      island_idx   <= (state_nx == ST_ISL_DATA) ? cnt_nx : 5'd0;
      island_first <= (state_nx == ST_ISL_DATA) && (cnt_nx == 5'd0);
    end
  end
`else
  assign island_idx   = 5'd0;
  assign island_first = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: a default 640x480 raster plus a 9-line raster
// whose frame wrap, vsync and island line come round within a short run.
module tb_hdmi_period_scheduler;

  localparam int H_TOTAL     = 800;
  localparam int FULL_FRAME  = 800 * 525;
  localparam int SHORT_FRAME = 800 * 9;
`ifdef HDMI_DATA_ISLAND_EN
  localparam int IM = 3, IG = 4, IP = 1, ISL_CYCLES = 32, ISL_FIRSTS = 1;
`else
  localparam int IM = 0, IG = 0, IP = 0, ISL_CYCLES = 0, ISL_FIRSTS = 0;
`endif

  typedef struct {
    int dut;
    int frame;
    int cx;
    int cy;
    int mode;
    int ctl0;
    int ctl1;
    int ctl2;
    int idx;
  } vec_t;

  logic        clk_pixel = 1'b0;
  logic        rst_pixel = 1'b1;
  logic [2:0]  mode         [2];
  logic [1:0]  ctl0         [2];
  logic [1:0]  ctl1         [2];
  logic [1:0]  ctl2         [2];
  logic [10:0] cx           [2];
  logic [9:0]  cy           [2];
  logic        video_active [2];
  logic [4:0]  island_idx   [2];
  logic        island_first [2];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  bit counting = 1'b0;
  int line0_video = 0, line0_guard = 0, line0_pre = 0, line0_hsync = 0;
  int isl_cycles = 0, isl_firsts = 0;
  vec_t vecs[$];

  always #5 clk_pixel = ~clk_pixel;

  hdmi_period_scheduler dut_full (
    .clk_pixel(clk_pixel), .rst_pixel(rst_pixel),
    .mode(mode[0]), .ctl0(ctl0[0]), .ctl1(ctl1[0]), .ctl2(ctl2[0]),
    .cx(cx[0]), .cy(cy[0]), .video_active(video_active[0]),
    .island_idx(island_idx[0]), .island_first(island_first[0])
  );

  hdmi_period_scheduler #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .ISLAND_LINE(4)
  ) dut_short (
    .clk_pixel(clk_pixel), .rst_pixel(rst_pixel),
    .mode(mode[1]), .ctl0(ctl0[1]), .ctl1(ctl1[1]), .ctl2(ctl2[1]),
    .cx(cx[1]), .cy(cy[1]), .video_active(video_active[1]),
    .island_idx(island_idx[1]), .island_first(island_first[1])
  );

  function automatic vec_t mk(int dut, int frame, int x, int y, int m,
                              int c0, int c1, int c2, int idx);
    vec_t v;
    v.dut = dut; v.frame = frame; v.cx = x; v.cy = y; v.mode = m;
    v.ctl0 = c0; v.ctl1 = c1; v.ctl2 = c2; v.idx = idx;
    return v;
  endfunction

  task automatic compareVal(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tally();
    if (counting && cyc < H_TOTAL) begin
      if (mode[0] == 3'd1) line0_video++;
      if (mode[0] == 3'd2) line0_guard++;
      if (ctl1[0] == 2'b01) line0_pre++;
      if (ctl0[0][0] == 1'b0) line0_hsync++;
    end
    if (counting && cyc < SHORT_FRAME) begin
      if (mode[1] == 3'd3) isl_cycles++;
      if (island_first[1]) isl_firsts++;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_pixel);
    #1;
    cyc++;
    tally();
  endtask

  task automatic applyStimulus(input vec_t v);
    int target;
    target = v.frame * ((v.dut == 0) ? FULL_FRAME : SHORT_FRAME) + v.cy * H_TOTAL + v.cx;
    if (cyc > target) compareVal("table_order", cyc, target);
    while (cyc < target) stepCycle();
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    string t;
    int d;
    d = v.dut;
    t = $sformatf("v%0d_d%0d_f%0d_y%0d_x%0d", i, d, v.frame, v.cy, v.cx);
    compareVal({t, "_cx"},    int'(cx[d]),   v.cx);
    compareVal({t, "_cy"},    int'(cy[d]),   v.cy);
    compareVal({t, "_mode"},  int'(mode[d]), v.mode);
    compareVal({t, "_ctl0"},  int'(ctl0[d]), v.ctl0);
    compareVal({t, "_ctl1"},  int'(ctl1[d]), v.ctl1);
    compareVal({t, "_ctl2"},  int'(ctl2[d]), v.ctl2);
    compareVal({t, "_vact"},  int'(video_active[d]), int'(v.mode == 1));
    compareVal({t, "_first"}, int'(island_first[d]), int'(v.mode == 3 && v.idx == 0));
    if (v.mode == 3) compareVal({t, "_idx"}, int'(island_idx[d]), v.idx);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Default raster: reset exit, line 0 sync/preamble/guard, line 1 video.
    vecs.push_back(mk(0, 0,   0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0,   1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 639, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 640, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 655, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 656, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 751, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 752, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 789, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 790, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 797, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 798, 0, 2, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 799, 0, 2, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 639, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 640, 1, 0, 3, 0, 0, 0));
    // Short raster: last active line, island line, vsync lines, frame wrap.
    vecs.push_back(mk(1, 0, 790, 2, 0, 3, 1, 0, 0));
    vecs.push_back(mk(1, 0, 799, 2, 2, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 3, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 639, 3, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 790, 3, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 798, 3, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 4, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  15, 4, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  16, 4, 0, 3, IP, IP, 0));
    vecs.push_back(mk(1, 0,  23, 4, 0, 3, IP, IP, 0));
    vecs.push_back(mk(1, 0,  24, 4, IG, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  25, 4, IG, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  26, 4, IM, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  27, 4, IM, 3, 0, 0, 1));
    vecs.push_back(mk(1, 0,  57, 4, IM, 3, 0, 0, 31));
    vecs.push_back(mk(1, 0,  58, 4, IG, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  59, 4, IG, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,  60, 4, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 656, 4, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 790, 4, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 700, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 6, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 7, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 790, 8, 0, 3, 1, 0, 0));
    vecs.push_back(mk(1, 0, 798, 8, 2, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1,   0, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1,   1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1,  26, 4, IM, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1,  40, 4, IM, 3, 0, 0, 14));

    $display("[TB] holding reset for 5 cycles");
    repeat (5) begin
      @(negedge clk_pixel);
      compareVal("rst_cx",   int'(cx[0]),   0);
      compareVal("rst_cy",   int'(cy[0]),   0);
      compareVal("rst_mode", int'(mode[0]), 0);
      compareVal("rst_ctl0", int'(ctl0[0]), 3);
      compareVal("rst_ctl1", int'(ctl1[0]), 0);
    end
    rst_pixel = 1'b0;
    cyc = 0;
    counting = 1'b1;
    tally();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    compareVal("line0_video_cycles", line0_video, 639);
    compareVal("line0_guard_cycles", line0_guard, 2);
    compareVal("line0_preamble_cycles", line0_pre, 8);
    compareVal("line0_hsync_cycles", line0_hsync, 96);
    compareVal("frame0_island_cycles", isl_cycles, ISL_CYCLES);
    compareVal("frame0_island_firsts", isl_firsts, ISL_FIRSTS);

    // Reset lands mid-island on the short raster; outputs must drop at once.
    $display("[TB] asserting reset mid-island");
    counting = 1'b0;
    #1 rst_pixel = 1'b1;
    #1;
    compareVal("midrst_mode",  int'(mode[1]),       0);
    compareVal("midrst_cx",    int'(cx[1]),         0);
    compareVal("midrst_cy",    int'(cy[1]),         0);
    compareVal("midrst_ctl1",  int'(ctl1[1]),       0);
    compareVal("midrst_idx",   int'(island_idx[1]), 0);
    compareVal("midrst_first", int'(island_first[1]), 0);
    compareVal("midrst_full_cx", int'(cx[0]),       0);
    repeat (5) @(posedge clk_pixel);
    @(negedge clk_pixel);
    compareVal("midrst_hold_cx", int'(cx[1]), 0);
    rst_pixel = 1'b0;
    cyc = 0;
    compareVal("restart_mode0", int'(mode[1]), 0);
    compareVal("restart_cx0",   int'(cx[1]),   0);
    stepCycle();
    compareVal("restart_cx1",   int'(cx[1]),   1);
    compareVal("restart_cy1",   int'(cy[1]),   0);
    compareVal("restart_mode1", int'(mode[1]), 1);
    compareVal("restart_full_mode1", int'(mode[0]), 1);
    while (cyc < 790) stepCycle();
    compareVal("restart_short_pre", int'(ctl1[1]), 1);
    compareVal("restart_full_pre",  int'(ctl1[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
